// File: rtl/coolgirl_cfg_regs.sv
// rtl/coolgirl_cfg_regs.sv - CoolGirl shadowed configuration register bank with atomic commit and lock
module coolgirl_cfg_regs #(
  parameter int unsigned  MAPPER_BITS    = 6,
  parameter logic [6:0]   PRG_MASK_RESET = 7'b1111000
) (
  input  logic                   m2,
  input  logic                   reset,
  input  logic                   romsel,
  input  logic                   cpu_rw_in,
  input  logic [14:0]            cpu_addr_in,
  input  logic [7:0]             cpu_data_in,
  output logic [12:0]            cpu_base,
  output logic [6:0]             prg_mask,
  output logic [4:0]             chr_mask,
  output logic [1:0]             sram_page,
  output logic [MAPPER_BITS-1:0] mapper_sel,
  output logic                   sram_enabled,
  output logic                   map_rom_on_6000,
  output logic                   prg_write_enabled,
  output logic                   chr_write_enabled,
  output logic                   four_screen,
  output logic                   cfg_locked,
  output logic                   commit_pulse
);

  logic [12:0]            sh_base;
  logic [6:0]             sh_prg_mask;
  logic [4:0]             sh_chr_mask;
  logic [1:0]             sh_sram_page;
  logic [MAPPER_BITS-1:0] sh_mapper;
  logic                   sh_sram_enabled;
  logic                   sh_map_rom_on_6000;
  logic                   sh_prg_write_enabled;
  logic                   sh_chr_write_enabled;
  logic                   sh_four_screen;

  logic       wr;
  logic       wr_en;
  logic [2:0] reg_idx;
  logic       commit;
  logic       lock_req;
  logic       unused_addr;

  assign wr       = !cpu_rw_in && romsel && (cpu_addr_in[14:12] == 3'b101);
  assign wr_en    = wr && !cfg_locked;
  assign reg_idx  = cpu_addr_in[2:0];
  assign commit   = wr_en && (reg_idx == 3'd6) && cpu_data_in[0];
  assign lock_req = wr_en && (reg_idx == 3'd6) && cpu_data_in[7];

  // The bank mirrors every 8 bytes across $5000-$5FFF.
  assign unused_addr = &{1'b0, cpu_addr_in[11:3]};

  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      sh_base              <= '0;
      sh_prg_mask          <= PRG_MASK_RESET;
      sh_chr_mask          <= '0;
      sh_sram_page         <= '0;
      sh_mapper            <= '0;
      sh_sram_enabled      <= 1'b0;
      sh_map_rom_on_6000   <= 1'b0;
      sh_prg_write_enabled <= 1'b0;
      sh_chr_write_enabled <= 1'b0;
      sh_four_screen       <= 1'b0;
    end else if (wr_en) begin
      case (reg_idx)
        3'd0: sh_base[12:5] <= cpu_data_in;
        3'd1: sh_base[4:0]  <= cpu_data_in[7:3];
        3'd2: sh_prg_mask   <= cpu_data_in[6:0];
        3'd3: sh_chr_mask   <= cpu_data_in[4:0];
        3'd4: sh_mapper     <= MAPPER_BITS'(cpu_data_in);
        3'd5: begin
          sh_sram_page         <= cpu_data_in[1:0];
          sh_sram_enabled      <= cpu_data_in[2];
          sh_map_rom_on_6000   <= cpu_data_in[3];
          sh_prg_write_enabled <= cpu_data_in[4];
          sh_chr_write_enabled <= cpu_data_in[5];
          sh_four_screen       <= cpu_data_in[6];
        end
        default: ;
      endcase
    end
  end

  // Active set is loaded from the shadows in one edge so mappings switch atomically.
  always_ff @(negedge m2 or posedge reset) begin
    if (reset) begin
      cpu_base          <= '0;
      prg_mask          <= PRG_MASK_RESET;
      chr_mask          <= '0;
      sram_page         <= '0;
      mapper_sel        <= '0;
      sram_enabled      <= 1'b0;
      map_rom_on_6000   <= 1'b0;
      prg_write_enabled <= 1'b0;
      chr_write_enabled <= 1'b0;
      four_screen       <= 1'b0;
      cfg_locked        <= 1'b0;
      commit_pulse      <= 1'b0;
    end else begin
      commit_pulse <= commit;
      if (lock_req) begin
        cfg_locked <= 1'b1;
      end
      if (commit) begin
        cpu_base          <= sh_base;
        prg_mask          <= sh_prg_mask;
        chr_mask          <= sh_chr_mask;
        sram_page         <= sh_sram_page;
        mapper_sel        <= sh_mapper;
        sram_enabled      <= sh_sram_enabled;
        map_rom_on_6000   <= sh_map_rom_on_6000;
        prg_write_enabled <= sh_prg_write_enabled;
        chr_write_enabled <= sh_chr_write_enabled;
        four_screen       <= sh_four_screen;
      end
    end
  end

endmodule

// File: tb/tb_coolgirl_cfg_regs.sv
// tb/tb_coolgirl_cfg_regs.sv - directed self-checking bench for coolgirl_cfg_regs
module tb_coolgirl_cfg_regs;

  logic        m2;
  logic        reset;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic [12:0] cpu_base;
  logic [6:0]  prg_mask;
  logic [4:0]  chr_mask;
  logic [1:0]  sram_page;
  logic [5:0]  mapper_sel;
  logic        sram_enabled;
  logic        map_rom_on_6000;
  logic        prg_write_enabled;
  logic        chr_write_enabled;
  logic        four_screen;
  logic        cfg_locked;
  logic        commit_pulse;

  int compared = 0;
  int mismatched = 0;

  coolgirl_cfg_regs #(.MAPPER_BITS(6), .PRG_MASK_RESET(7'b1111000)) dut (
    .m2(m2), .reset(reset), .romsel(romsel), .cpu_rw_in(cpu_rw_in),
    .cpu_addr_in(cpu_addr_in), .cpu_data_in(cpu_data_in),
    .cpu_base(cpu_base), .prg_mask(prg_mask), .chr_mask(chr_mask),
    .sram_page(sram_page), .mapper_sel(mapper_sel),
    .sram_enabled(sram_enabled), .map_rom_on_6000(map_rom_on_6000),
    .prg_write_enabled(prg_write_enabled), .chr_write_enabled(chr_write_enabled),
    .four_screen(four_screen), .cfg_locked(cfg_locked), .commit_pulse(commit_pulse)
  );

  initial m2 = 1'b0;
  always #5 m2 = ~m2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    romsel      = 1'b1;
    cpu_rw_in   = 1'b1;
    cpu_addr_in = 15'h0000;
    cpu_data_in = 8'h00;
  endtask

  // Drives one bus cycle during m2 high; returns just after the sampling falling edge.
  task automatic bus(input logic [15:0] addr, input logic [7:0] data,
                     input logic rs, input logic rw);
    @(posedge m2);
    #1;
    romsel      = rs;
    cpu_rw_in   = rw;
    cpu_addr_in = addr[14:0];
    cpu_data_in = data;
    @(negedge m2);
    #1;
    set_idle();
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    bus(addr, data, 1'b1, 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge m2);
    @(negedge m2);
    #1;
  endtask

  task automatic do_reset();
    @(posedge m2);
    #1 reset = 1'b1;
    repeat (2) idle_cycle();
    @(posedge m2);
    #1 reset = 1'b0;
    @(negedge m2);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    set_idle();
    do_reset();

    chk("rst_base",   32'(cpu_base),     32'h0);
    chk("rst_prgm",   32'(prg_mask),     32'h78);
    chk("rst_chrm",   32'(chr_mask),     32'h0);
    chk("rst_sram",   32'(sram_page),    32'h0);
    chk("rst_mapper", 32'(mapper_sel),   32'h0);
    chk("rst_flags",  32'({sram_enabled, map_rom_on_6000, prg_write_enabled,
                          chr_write_enabled, four_screen}), 32'h0);
    chk("rst_lock",   32'(cfg_locked),   32'h0);
    chk("rst_pulse",  32'(commit_pulse), 32'h0);

    // Shadow writes must not leak to outputs before commit.
    wr(16'h5000, 8'hAB);
    wr(16'h5001, 8'hC8);
    wr(16'h5002, 8'h7F);
    wr(16'h5004, 8'h04);
    chk("pre_base",   32'(cpu_base),     32'h0);
    chk("pre_prgm",   32'(prg_mask),     32'h78);
    chk("pre_mapper", 32'(mapper_sel),   32'h0);
    wr(16'h5006, 8'h01);
    chk("c1_base",    32'(cpu_base),     32'h1579);
    chk("c1_prgm",    32'(prg_mask),     32'h7F);
    chk("c1_mapper",  32'(mapper_sel),   32'h4);
    chk("c1_pulse",   32'(commit_pulse), 32'h1);
    idle_cycle();
    chk("c1_pulse_off", 32'(commit_pulse), 32'h0);

    // Flags plus commit-and-lock in one write.
    wr(16'h5005, 8'h7D);
    chk("pre_sram",   32'(sram_page),    32'h0);
    wr(16'h5006, 8'h81);
    chk("lk_sram",    32'(sram_page),    32'h1);
    chk("lk_flags",   32'({sram_enabled, map_rom_on_6000, prg_write_enabled,
                          chr_write_enabled, four_screen}), 32'h1F);
    chk("lk_lock",    32'(cfg_locked),   32'h1);
    chk("lk_pulse",   32'(commit_pulse), 32'h1);
    wr(16'h5000, 8'hFF);
    wr(16'h5006, 8'h01);
    chk("lk_base",    32'(cpu_base),     32'h1579);
    chk("lk_pulse0",  32'(commit_pulse), 32'h0);
    chk("lk_held",    32'(cfg_locked),   32'h1);

    // Lock alone leaves active registers untouched.
    do_reset();
    wr(16'h5000, 8'h12);
    wr(16'h5006, 8'h80);
    chk("lka_lock",   32'(cfg_locked),   32'h1);
    chk("lka_base",   32'(cpu_base),     32'h0);
    chk("lka_pulse",  32'(commit_pulse), 32'h0);

    // Decode filtering and mirroring.
    do_reset();
    chk("rst2_lock",  32'(cfg_locked),   32'h0);
    bus(16'h5000, 8'h55, 1'b0, 1'b0);
    wr(16'h4000, 8'h55);
    bus(16'h5000, 8'h55, 1'b1, 1'b1);
    wr(16'h5006, 8'h01);
    chk("dec_base",   32'(cpu_base),     32'h0);
    wr(16'h5FF8, 8'h55);
    wr(16'h5FFE, 8'h01);
    chk("mir_base",   32'(cpu_base),     32'h0AA0);

    // Reset mid m2-high discards pending shadow writes.
    wr(16'h5000, 8'hAB);
    wr(16'h5001, 8'hC8);
    wr(16'h5006, 8'h01);
    chk("sh_base",    32'(cpu_base),     32'h1579);
    wr(16'h5000, 8'h01);
    chk("sh_nochg",   32'(cpu_base),     32'h1579);
    @(posedge m2);
    #2 reset = 1'b1;
    #1;
    chk("async_base", 32'(cpu_base),     32'h0);
    #1 reset = 1'b0;
    wr(16'h5006, 8'h01);
    chk("post_base",  32'(cpu_base),     32'h0);
    chk("post_prgm",  32'(prg_mask),     32'h78);
    chk("post_pulse", 32'(commit_pulse), 32'h1);

    // Back-to-back commits, unused data bits dropped, reserved register inert.
    wr(16'h5003, 8'hFF);
    wr(16'h5004, 8'hFF);
    wr(16'h5002, 8'hFF);
    wr(16'h5007, 8'hFF);
    wr(16'h5006, 8'h01);
    chk("bb_chrm",    32'(chr_mask),     32'h1F);
    chk("bb_mapper",  32'(mapper_sel),   32'h3F);
    chk("bb_prgm",    32'(prg_mask),     32'h7F);
    chk("bb_base",    32'(cpu_base),     32'h0);
    chk("bb_pulse1",  32'(commit_pulse), 32'h1);
    wr(16'h5006, 8'h01);
    chk("bb_pulse2",  32'(commit_pulse), 32'h1);
    idle_cycle();
    chk("bb_pulse3",  32'(commit_pulse), 32'h0);
    chk("bb_lock",    32'(cfg_locked),   32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
